program_memory_arbiter: RTL

Shares the single program memory read port (addr/read_request in, instr/data_valid out) between NUM_REQ requesters, e.g. CPU fetch unit, debug reader, and sprite/asset loader. Grants one transaction at a time using round-robin arbitration and holds all grants until program memory reports ready. Each transaction has a response timeout so that a stuck memory cannot deadlock the consumers. Sits between the program memory block and its consumers.

---
 rtl/program_memory_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/program_memory_arbiter.sv
// ---------------------------------------------------------------------------
// program_memory_arbiter
//
// Purpose: shares the single read port of the program memory between
// NUM_REQ requesters, such as the CPU fetch unit, the debug reader and the
// asset loader. Only one transaction is in flight at a time. Each transaction
// moves through IDLE (arbitrate and latch the address), ISSUE (pulse the
// memory read request) and WAIT (collect the data or time out). A timeout
// returns an error response so that a stuck memory cannot block the consumers.
//
// Optional feature macro: PROGRAM_MEMORY_ARB_FIXED_PRIORITY_EN
//   defined   : fixed priority, the lowest-index valid requester always wins
//   undefined : round-robin, starting the search just after the last grant
//
// Ports:
//   clk_in               system clock
//   rst_in               asynchronous active-low reset
//   mem_ready_in         program memory initialised; no grants while low
//   req_valid_in         per-requester read request
//   req_addr_in          packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_ready_out        one-hot accept pulse
//   rsp_valid_out        one-hot response pulse
//   rsp_data_out         shared response data, holds between responses
//   rsp_error_out        response was a timeout
//   busy_out             transaction in flight
//   mem_addr_out         address to program memory
//   mem_read_request_out single-cycle read request to program memory
//   mem_instr_in         instruction word from program memory
//   mem_data_valid_in    data valid from program memory
// ---------------------------------------------------------------------------
module program_memory_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      mem_ready_in,
    input  logic [NUM_REQ-1:0]        req_valid_in,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_in,
    output logic [NUM_REQ-1:0]        req_ready_out,
    output logic [NUM_REQ-1:0]        rsp_valid_out,
    output logic [DATA_W-1:0]         rsp_data_out,
    output logic                      rsp_error_out,
    output logic                      busy_out,
    output logic [ADDR_W-1:0]         mem_addr_out,
    output logic                      mem_read_request_out,
    input  logic [DATA_W-1:0]         mem_instr_in,
    input  logic                      mem_data_valid_in
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [NUM_REQ-1:0] ONE_HOT_0   = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_grant;
    logic [CNT_W-1:0] r_cnt;

    logic [IDX_W-1:0]  w_winner;
    logic [ADDR_W-1:0] w_win_addr;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_grant_ok;

`ifdef PROGRAM_MEMORY_ARB_FIXED_PRIORITY_EN
    // Lowest-index valid requester; scanning downward lets the lowest set bit win.
    function automatic logic [IDX_W-1:0] f_pick(input logic [NUM_REQ-1:0] valid);
        logic [IDX_W-1:0] pick;
        pick = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (valid[k]) begin
                pick = IDX_W'(k);
            end
        end
        return pick;
    endfunction

    assign w_winner = f_pick(req_valid_in);
`else
    logic [IDX_W-1:0] r_last_grant;

    // First set bit strictly after 'last', wrapping modulo NUM_REQ.
    function automatic logic [IDX_W-1:0] f_pick(input logic [NUM_REQ-1:0] valid,
                                                input logic [IDX_W-1:0]   last);
        logic [IDX_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!found && valid[idx]) begin
                pick  = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign w_winner = f_pick(req_valid_in, r_last_grant);
`endif

    assign w_win_addr = req_addr_in[w_winner*ADDR_W +: ADDR_W];
    assign w_cnt_inc  = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    assign w_grant_ok = mem_ready_in && (|req_valid_in);

    // Transaction FSM; every output is a register written here.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state              <= ST_IDLE;
            r_grant              <= '0;
            r_cnt                <= '0;
`ifndef PROGRAM_MEMORY_ARB_FIXED_PRIORITY_EN
            r_last_grant         <= IDX_W'(NUM_REQ - 1);
`endif
            req_ready_out        <= '0;
            rsp_valid_out        <= '0;
            rsp_data_out         <= '0;
            rsp_error_out        <= 1'b0;
            busy_out             <= 1'b0;
            mem_addr_out         <= '0;
            mem_read_request_out <= 1'b0;
        end else begin
            // Pulses default low; data and address hold.
            req_ready_out        <= '0;
            rsp_valid_out        <= '0;
            rsp_error_out        <= 1'b0;
            mem_read_request_out <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A stray data_valid here is ignored by construction.
                    if (w_grant_ok) begin
                        req_ready_out <= ONE_HOT_0 << w_winner;
                        mem_addr_out  <= w_win_addr;
                        r_grant       <= w_winner;
                        r_state       <= ST_ISSUE;
                        busy_out      <= 1'b1;
                    end else begin
                        busy_out      <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    mem_read_request_out <= 1'b1;
                    r_cnt                <= '0;
                    r_state              <= ST_WAIT;
                    busy_out             <= 1'b1;
                end
                ST_WAIT: begin
                    // Data takes precedence over a timeout in the same cycle.
                    if (mem_data_valid_in) begin
                        rsp_valid_out <= ONE_HOT_0 << r_grant;
                        rsp_data_out  <= mem_instr_in;
                        rsp_error_out <= 1'b0;
`ifndef PROGRAM_MEMORY_ARB_FIXED_PRIORITY_EN
                        r_last_grant  <= r_grant;
`endif
                        r_state       <= ST_IDLE;
                        busy_out      <= 1'b0;
                    end else if (w_cnt_inc == TIMEOUT_LIM) begin
                        rsp_valid_out <= ONE_HOT_0 << r_grant;
                        rsp_data_out  <= '0;
                        rsp_error_out <= 1'b1;
`ifndef PROGRAM_MEMORY_ARB_FIXED_PRIORITY_EN
                        r_last_grant  <= r_grant;
`endif
                        r_state       <= ST_IDLE;
                        busy_out      <= 1'b0;
                    end else begin
                        r_cnt         <= w_cnt_inc;
                        busy_out      <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule
